// File: rtl/norm1_mul_pipe_if.sv
// Operand/result stream bundle for norm1_mul_pipe.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface norm1_mul_pipe_if #(
   parameter int unsigned din0_WIDTH = 41,
   parameter int unsigned din1_WIDTH = 6,
   parameter int unsigned dout_WIDTH = 47
);
   logic                  in_valid;
   logic                  in_ready;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  out_valid;
   logic                  out_ready;
   logic [dout_WIDTH-1:0] dout;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, dout
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, dout
   );
endinterface

// File: rtl/norm1_mul_pipe.sv
// Pipelined valid/ready integer multiplier with collapsing bubbles and full backpressure.
// Optional NORM1_MUL_ROUND_EN adds SHIFT: round-half-up right shift with saturation.
module norm1_mul_pipe #(
   parameter int unsigned din0_WIDTH  = 41,
   parameter int unsigned din1_WIDTH  = 6,
   parameter int unsigned dout_WIDTH  = 47,
   parameter bit          DIN0_SIGNED = 1'b0,
   parameter bit          DIN1_SIGNED = 1'b0,
   parameter int unsigned NUM_STAGE   = 3
`ifdef NORM1_MUL_ROUND_EN
   ,
   parameter int unsigned SHIFT       = 0
`endif
) (
   input logic             ap_clk,
   input logic             ap_rst_n,
   norm1_mul_pipe_if.slave bus
);

   localparam int unsigned PW         = din0_WIDTH + din1_WIDTH;
   localparam int unsigned EW         = (dout_WIDTH > PW) ? dout_WIDTH : PW;
   localparam bit          ANY_SIGNED = DIN0_SIGNED || DIN1_SIGNED;

   if (NUM_STAGE == 0 || NUM_STAGE > 8) begin : g_bad_num_stage
      $error("norm1_mul_pipe: NUM_STAGE must be in 1..8");
   end

   logic [EW-1:0]         a_ext;
   logic [EW-1:0]         b_ext;
   logic [EW-1:0]         prod_ext;
   logic [dout_WIDTH-1:0] res_c;

   // Extending both operands to at least the product width keeps the low bits exact
   // and yields the correctly extended product when dout is wider than the product.
   always_comb begin : p_mul
      a_ext = EW'(bus.din0);
      b_ext = EW'(bus.din1);
      if (DIN0_SIGNED) a_ext = EW'($signed(bus.din0));
      if (DIN1_SIGNED) b_ext = EW'($signed(bus.din1));
      prod_ext = a_ext * b_ext;
   end

`ifdef NORM1_MUL_ROUND_EN
   localparam int unsigned           RW   = EW + 2;
   localparam logic [RW-1:0]         RND  = (SHIFT == 0) ? '0 : (RW'(1) << (SHIFT - 1));
   localparam logic [dout_WIDTH-1:0] SMIN = dout_WIDTH'(1) << (dout_WIDTH - 1);

   if (SHIFT >= PW) begin : g_bad_shift
      $error("norm1_mul_pipe: SHIFT must be below din0_WIDTH+din1_WIDTH");
   end

   logic signed [RW-1:0] p_r;
   logic signed [RW-1:0] sum_r;
   logic signed [RW-1:0] sh_r;

   // Two guard bits absorb the rounding carry so saturation sees the true value.
   always_comb begin : p_round
      p_r = RW'(prod_ext);
      if (ANY_SIGNED) p_r = RW'($signed(prod_ext));
      sum_r = p_r + $signed(RND);
      sh_r  = sum_r >>> SHIFT;
      res_c = sh_r[dout_WIDTH-1:0];
      if (ANY_SIGNED) begin
         if (!(&sh_r[RW-1:dout_WIDTH-1]) && (|sh_r[RW-1:dout_WIDTH-1]))
            res_c = sh_r[RW-1] ? SMIN : ~SMIN;
      end else if (|sh_r[RW-1:dout_WIDTH]) begin
         res_c = '1;
      end
   end
`else
   assign res_c = prod_ext[dout_WIDTH-1:0];
`endif

   logic [NUM_STAGE-1:0]  v_q;
   logic [NUM_STAGE-1:0]  v_d;
   logic [NUM_STAGE-1:0]  adv_c;
   logic [dout_WIDTH-1:0] data_q [NUM_STAGE];
   logic [dout_WIDTH-1:0] data_d [NUM_STAGE];

   // Stage k can move when the sink is ready or any stage from k upward is empty.
   always_comb begin : p_adv
      adv_c = '0;
      for (int k = 0; k < int'(NUM_STAGE); k++) begin
         adv_c[k] = bus.out_ready ||
                    ((v_q | NUM_STAGE'((32'd1 << k) - 32'd1)) != {NUM_STAGE{1'b1}});
      end
   end

   always_comb begin : p_next
      v_d    = v_q;
      data_d = data_q;
      if (adv_c[0]) begin
         v_d[0] = bus.in_valid;
         if (bus.in_valid) data_d[0] = res_c;
      end
      for (int k = 1; k < int'(NUM_STAGE); k++) begin
         if (adv_c[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) data_d[k] = data_q[k-1];
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin : p_regs
      if (!ap_rst_n) begin
         v_q <= '0;
         for (int k = 0; k < int'(NUM_STAGE); k++) data_q[k] <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   assign bus.in_ready  = ap_rst_n && adv_c[0];
   assign bus.out_valid = v_q[NUM_STAGE-1];
   assign bus.dout      = data_q[NUM_STAGE-1];

endmodule

// File: tb/tb_norm1_mul_pipe.sv
// Directed self-checking bench for norm1_mul_pipe (unsigned, signed, stalls, reset,
// and the rounding variant when NORM1_MUL_ROUND_EN is defined).
module tb_norm1_mul_pipe;

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   always #5 ap_clk = ~ap_clk;

   localparam logic [46:0] MAXP = 47'd138538465099713;

   norm1_mul_pipe_if #(.din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47)) b0 ();
   norm1_mul_pipe_if #(.din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47)) b1 ();

   norm1_mul_pipe #(
      .din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47),
      .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0), .NUM_STAGE(3)
   ) u0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b0));

   norm1_mul_pipe #(
      .din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47),
      .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b1), .NUM_STAGE(3)
   ) u1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b1));

`ifdef NORM1_MUL_ROUND_EN
   norm1_mul_pipe_if #(.din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47)) b3 ();
   norm1_mul_pipe_if #(.din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(8))  b4 ();

   norm1_mul_pipe #(
      .din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(47),
      .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0), .NUM_STAGE(3), .SHIFT(4)
   ) u3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b3));

   norm1_mul_pipe #(
      .din0_WIDTH(41), .din1_WIDTH(6), .dout_WIDTH(8),
      .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0), .NUM_STAGE(3), .SHIFT(4)
   ) u4 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b4));
`endif

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_reset;
      b0.in_valid = 1'b1; b0.din0 = 41'd3; b0.din1 = 6'd2; b0.out_ready = 1'b1;
      repeat (2) @(posedge ap_clk);
      #1;
      total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", b0.out_valid); end
      total++; if (b0.dout !== 47'd0) begin bad++; $display("FAIL rst_dout got=%0h exp=0", b0.dout); end
      total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", b0.in_ready); end
      total++; if (b1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid_b1 got=%0b exp=0", b1.out_valid); end
      b0.in_valid = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick();
      total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0b exp=1", b0.in_ready); end
   endtask

   task automatic test_unsigned_max;
      b0.out_ready = 1'b1;
      b0.in_valid  = 1'b1;
      b0.din0      = 41'h1FF_FFFF_FFFF;
      b0.din1      = 6'd63;
      #1;
      total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL umax_in_ready got=%0b exp=1", b0.in_ready); end
      tick();
      b0.in_valid = 1'b0;
      for (int e = 0; e < 4; e++) begin
         total++;
         if (b0.out_valid !== (e == 2)) begin
            bad++; $display("FAIL umax_latency edge+%0d got=%0b exp=%0b", e, b0.out_valid, (e == 2));
         end
         if (e == 2) begin
            total++; if (b0.dout !== MAXP) begin bad++; $display("FAIL umax_dout got=%0d exp=%0d", b0.dout, MAXP); end
         end
         tick();
      end
   endtask

   task automatic test_signed;
      b1.in_valid = 1'b1; b1.din0 = 41'd5; b1.din1 = 6'h3F;
      tick();
      b1.din0 = 41'd1; b1.din1 = 6'h20;
      tick();
      b1.in_valid = 1'b0;
      tick();
      total++; if (b1.out_valid !== 1'b1 || b1.dout !== 47'h7FFF_FFFF_FFFB) begin
         bad++; $display("FAIL signed_m1 got=%0b/%0h exp=1/7ffffffffffb", b1.out_valid, b1.dout);
      end
      tick();
      total++; if (b1.out_valid !== 1'b1 || b1.dout !== 47'h7FFF_FFFF_FFE0) begin
         bad++; $display("FAIL signed_m32 got=%0b/%0h exp=1/7fffffffffe0", b1.out_valid, b1.dout);
      end
      tick();
      total++; if (b1.out_valid !== 1'b0) begin bad++; $display("FAIL signed_drain got=%0b exp=0", b1.out_valid); end
   endtask

   task automatic test_backpressure;
      b0.out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         b0.in_valid = 1'b1; b0.din0 = 41'(i); b0.din1 = 6'd1;
         #1;
         total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready item%0d got=%0b exp=1", i, b0.in_ready); end
         tick();
      end
      b0.din0 = 41'd4; b0.din1 = 6'd1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready cyc%0d got=%0b exp=0", c, b0.in_ready); end
         total++; if (b0.out_valid !== 1'b1 || b0.dout !== 47'd1) begin
            bad++; $display("FAIL bp_hold cyc%0d got=%0b/%0d exp=1/1", c, b0.out_valid, b0.dout);
         end
         if (c < 2) tick();
      end
      b0.out_ready = 1'b1;
      #1;
      total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", b0.in_ready); end
      tick();
      b0.in_valid = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         total++; if (b0.out_valid !== 1'b1 || b0.dout !== 47'(k)) begin
            bad++; $display("FAIL bp_order got=%0b/%0d exp=1/%0d", b0.out_valid, b0.dout, k);
         end
         tick();
      end
      total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", b0.out_valid); end
   endtask

   task automatic test_sparse;
      logic [46:0] exp_q[$];
      logic [46:0] e;
      int sent = 0;
      int recv = 0;
      bit acc, xfer;
      b0.in_valid = 1'b0;
      for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
         if (!b0.in_valid && (cyc % 3 == 0) && sent < 8) begin
            b0.in_valid = 1'b1;
            b0.din0 = 41'(1000 + 17 * sent);
            b0.din1 = 6'(sent + 3);
         end
         b0.out_ready = ((cyc % 4) < 2);
         #1;
         acc  = b0.in_valid && b0.in_ready;
         xfer = b0.out_valid && b0.out_ready;
         if (acc) begin
            exp_q.push_back(47'((1000 + 17 * sent) * (sent + 3)));
            sent++;
         end
         if (xfer) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL sparse_extra got=%0d exp=none", b0.dout);
            end else begin
               e = exp_q.pop_front();
               if (b0.dout !== e) begin bad++; $display("FAIL sparse_data got=%0d exp=%0d", b0.dout, e); end
            end
            recv++;
         end
         tick();
         if (acc) b0.in_valid = 1'b0;
      end
      total++; if (recv !== 8) begin bad++; $display("FAIL sparse_count got=%0d exp=8", recv); end
      b0.out_ready = 1'b1;
      repeat (4) begin
         tick();
         total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL sparse_dup got=%0b exp=0", b0.out_valid); end
      end
   endtask

   task automatic test_back_to_back;
      logic [46:0] exp_q[$];
      logic [46:0] e;
      int sent = 0;
      int recv = 0;
      int first = -1;
      int last = -1;
      int stalls = 0;
      bit acc;
      b0.out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && recv < 100; cyc++) begin
         b0.in_valid = (sent < 100);
         b0.din0 = 41'(sent * 1000 + 7);
         b0.din1 = 6'(sent % 64);
         #1;
         if (b0.in_valid && !b0.in_ready) stalls++;
         acc = b0.in_valid && b0.in_ready;
         if (acc) begin
            exp_q.push_back(47'((sent * 1000 + 7) * (sent % 64)));
            sent++;
         end
         if (b0.out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_extra got=%0d exp=none", b0.dout);
            end else begin
               e = exp_q.pop_front();
               if (b0.dout !== e) begin bad++; $display("FAIL b2b_data got=%0d exp=%0d", b0.dout, e); end
            end
            if (first < 0) first = cyc;
            last = cyc;
            recv++;
         end
         tick();
      end
      b0.in_valid = 1'b0;
      total++; if (recv !== 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", recv); end
      total++; if (last - first !== 99) begin bad++; $display("FAIL b2b_span got=%0d exp=99", last - first); end
      total++; if (stalls !== 0) begin bad++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
      tick();
   endtask

   task automatic test_mid_reset;
      int lat = 0;
      b0.out_ready = 1'b0;
      b0.in_valid = 1'b1; b0.din0 = 41'd5; b0.din1 = 6'd5;
      tick();
      b0.din0 = 41'd6; b0.din1 = 6'd6;
      tick();
      b0.in_valid = 1'b0;
      tick();
      total++; if (b0.out_valid !== 1'b1 || b0.dout !== 47'd25) begin
         bad++; $display("FAIL mrst_pre got=%0b/%0d exp=1/25", b0.out_valid, b0.dout);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%0b exp=0", b0.out_valid); end
      total++; if (b0.dout !== 47'd0) begin bad++; $display("FAIL mrst_dout got=%0d exp=0", b0.dout); end
      total++; if (b0.in_ready !== 1'b0) begin bad++; $display("FAIL mrst_in_ready got=%0b exp=0", b0.in_ready); end
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      b0.out_ready = 1'b1;
      tick();
      repeat (3) begin
         total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale got=%0b/%0d exp=0", b0.out_valid, b0.dout); end
         tick();
      end
      b0.in_valid = 1'b1; b0.din0 = 41'd7; b0.din1 = 6'd9;
      tick();
      b0.in_valid = 1'b0;
      while (!b0.out_valid && lat < 10) begin
         tick();
         lat++;
      end
      total++; if (lat !== 2) begin bad++; $display("FAIL mrst_latency got=%0d exp=2", lat); end
      total++; if (b0.dout !== 47'd63) begin bad++; $display("FAIL mrst_first got=%0d exp=63", b0.dout); end
      tick();
      total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_single got=%0b exp=0", b0.out_valid); end
   endtask

`ifdef NORM1_MUL_ROUND_EN
   task automatic test_round;
      b3.in_valid = 1'b1; b3.din0 = 41'd3; b3.din1 = 6'd8;
      b4.in_valid = 1'b1; b4.din0 = 41'h1FF_FFFF_FFFF; b4.din1 = 6'd63;
      tick();
      b3.din0 = 41'd1; b3.din1 = 6'd8;
      b4.in_valid = 1'b0;
      tick();
      b3.in_valid = 1'b0;
      tick();
      total++; if (b3.out_valid !== 1'b1 || b3.dout !== 47'd2) begin
         bad++; $display("FAIL round_3x8 got=%0b/%0d exp=1/2", b3.out_valid, b3.dout);
      end
      total++; if (b4.out_valid !== 1'b1 || b4.dout !== 8'd255) begin
         bad++; $display("FAIL round_sat got=%0b/%0d exp=1/255", b4.out_valid, b4.dout);
      end
      tick();
      total++; if (b3.out_valid !== 1'b1 || b3.dout !== 47'd1) begin
         bad++; $display("FAIL round_half_up got=%0b/%0d exp=1/1", b3.out_valid, b3.dout);
      end
      tick();
   endtask
`endif

   initial begin
      b1.in_valid = 1'b0; b1.din0 = '0; b1.din1 = '0; b1.out_ready = 1'b1;
`ifdef NORM1_MUL_ROUND_EN
      b3.in_valid = 1'b0; b3.din0 = '0; b3.din1 = '0; b3.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.din0 = '0; b4.din1 = '0; b4.out_ready = 1'b1;
`endif
      test_reset();
      test_unsigned_max();
      test_signed();
      test_backpressure();
      test_sparse();
      test_back_to_back();
`ifdef NORM1_MUL_ROUND_EN
      test_round();
`endif
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
